// File: rtl/demux_sched_pkg.sv
// Shared definitions for the round-robin demux scheduler: FSM encoding and
// default channel geometry.
package demux_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_CHANNELS = 8;
    localparam int DEF_SEL_W    = 3;

endpackage

// File: rtl/demux.sv
// One-to-many demultiplexer: routes `in` to the slot chosen by `sel`.
// Every unselected slot is driven to zero.
module demux
    import demux_sched_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = DEF_SEL_W
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [WIDTH-1:0]          in,
    output logic [CHANNELS*WIDTH-1:0] out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                out[i*WIDTH +: WIDTH] = in;
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set request at or above `ptr`,
// wrapping past the top channel back to channel 0.
module rr_pick
    import demux_sched_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = DEF_SEL_W
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    idx,
    output logic                any
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest request to ptr wins;
    // CHANNELS is a power of two, so the SEL_W-bit add wraps for free.
    always_comb begin
        idx  = ptr;
        any  = 1'b0;
        cand = ptr;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_scheduler.sv
// Round-robin scheduler that time-shares one serial input across CHANNELS
// requesters by sequencing the select of a demux, with a one-cycle gap per turn.
module demux_scheduler
    import demux_sched_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int WIDTH    = 1,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       req,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    output logic [SEL_W-1:0]          sel,
    output logic [CHANNELS-1:0]       grant,
    output logic                      busy,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [1:0]                state_dbg
);

    localparam int CNT_W = $clog2(DWELL) + 1;

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic [WIDTH-1:0]   gated_data;

    // Flow: in_valid qualifies in_data each cycle; there is no back-pressure,
    // data is delivered only in the cycle it is presented and only during GRANT.
    assign gated_data = in_data & {WIDTH{in_valid & (state == GRANT)}};
    assign state_dbg  = state;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    demux #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_demux (
        .sel (sel),
        .in  (gated_data),
        .out (out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    if (pick_any) begin
                        sel   <= pick_idx;
                        cnt   <= CNT_W'(DWELL - 1);
                        grant <= CHANNELS'(1) << pick_idx;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // A dropped request ends the turn early, same as dwell expiry.
                    if (cnt == '0 || !req[sel]) begin
                        grant <= '0;
                        ptr   <= sel + 1'b1;
                        state <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler: an 8-channel DWELL=4 instance plus a
// 4-channel DWELL=1, WIDTH=2 instance for the minimum-dwell case.
module tb_demux_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [0:0] in_data;
    logic       in_valid;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       busy;
    logic [7:0] out;
    logic [1:0] state_dbg;

    logic [3:0] req1;
    logic [1:0] in_data1;
    logic       in_valid1;
    logic [1:0] sel1;
    logic [3:0] grant1;
    logic       busy1;
    logic [7:0] out1;
    logic [1:0] state_dbg1;

    int errors;
    int checks;

    demux_scheduler #(
        .CHANNELS (8), .SEL_W (3), .WIDTH (1), .DWELL (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sel       (sel),
        .grant     (grant),
        .busy      (busy),
        .out       (out),
        .state_dbg (state_dbg)
    );

    demux_scheduler #(
        .CHANNELS (4), .SEL_W (2), .WIDTH (2), .DWELL (1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req1),
        .in_data   (in_data1),
        .in_valid  (in_valid1),
        .sel       (sel1),
        .grant     (grant1),
        .busy      (busy1),
        .out       (out1),
        .state_dbg (state_dbg1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        req1      = '0;
        in_data1  = '0;
        in_valid1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || out !== 8'h00) begin
            errors++;
            $display("FAIL reset_init: grant=%h sel=%0d busy=%b out=%h want 00/0/0/00",
                     grant, sel, busy, out);
        end
        req      = 8'hFF;
        in_valid = 1'b1;
        in_data  = 1'b1;
        tick();
        tick();
        checks++;
        if (grant !== 8'h01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_grant: grant=%h busy=%b want 01/1", grant, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || out !== 8'h00
            || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_async: grant=%h sel=%0d busy=%b out=%h st=%0d want zeros",
                     grant, sel, busy, out, state_dbg);
        end
        tick();
        checks++;
        if (grant !== 8'h00 || busy !== 1'b0 || out !== 8'h00) begin
            errors++;
            $display("FAIL reset_held: grant=%h busy=%b out=%h want 00/0/00", grant, busy, out);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] exp_g;
        logic       exp_b;
        do_reset();
        req      = 8'h08;
        in_valid = 1'b1;
        in_data  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_g = ((i % 6) < 4) ? 8'h08 : 8'h00;
            exp_b = ((i % 6) < 5);
            checks++;
            if (grant !== exp_g || out !== exp_g || busy !== exp_b || sel !== 3'd3) begin
                errors++;
                $display("FAIL single cyc%0d: grant=%h out=%h busy=%b sel=%0d want %h/%h/%b/3",
                         i, grant, out, busy, sel, exp_g, exp_g, exp_b);
            end
        end
    endtask

    task automatic test_all_requesting();
        logic [7:0] exp_g;
        logic [2:0] exp_s;
        do_reset();
        req      = 8'hFF;
        in_valid = 1'b1;
        in_data  = 1'b1;
        for (int i = 0; i < 54; i++) begin
            tick();
            exp_s = 3'((i / 6) % 8);
            exp_g = ((i % 6) < 4) ? (8'h01 << exp_s) : 8'h00;
            checks++;
            if (grant !== exp_g || sel !== exp_s) begin
                errors++;
                $display("FAIL all_req cyc%0d: grant=%h sel=%0d want %h/%0d",
                         i, grant, sel, exp_g, exp_s);
            end
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        req      = 8'h20;
        in_valid = 1'b1;
        in_data  = 1'b1;
        tick();
        tick();
        checks++;
        if (grant !== 8'h20 || sel !== 3'd5) begin
            errors++;
            $display("FAIL drop_granted: grant=%h sel=%0d want 20/5", grant, sel);
        end
        req = 8'h00;
        tick();
        checks++;
        if (grant !== 8'h00 || busy !== 1'b1 || out !== 8'h00 || sel !== 3'd5) begin
            errors++;
            $display("FAIL drop_gap: grant=%h busy=%b out=%h sel=%0d want 00/1/00/5",
                     grant, busy, out, sel);
        end
        req = 8'h41;
        tick();
        checks++;
        if (busy !== 1'b0 || grant !== 8'h00) begin
            errors++;
            $display("FAIL drop_idle: busy=%b grant=%h want 0/00", busy, grant);
        end
        tick();
        checks++;
        if (grant !== 8'h40 || sel !== 3'd6) begin
            errors++;
            $display("FAIL drop_ptr: grant=%h sel=%0d want 40/6", grant, sel);
        end
    endtask

    task automatic test_wrap_gating();
        do_reset();
        req      = 8'h80;
        in_valid = 1'b0;
        in_data  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (grant !== 8'h80 || out !== 8'h00) begin
                errors++;
                $display("FAIL wrap_gated cyc%0d: grant=%h out=%h want 80/00", i, grant, out);
            end
        end
        req = 8'h81;
        tick();
        tick();
        in_valid = 1'b1;
        tick();
        checks++;
        if (grant !== 8'h01 || sel !== 3'd0 || out !== 8'h01) begin
            errors++;
            $display("FAIL wrap_ch0: grant=%h sel=%0d out=%h want 01/0/01", grant, sel, out);
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (out !== 8'h00) begin
            errors++;
            $display("FAIL wrap_valid_low: out=%h want 00", out);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        tick();
        checks++;
        if (grant !== 8'h80 || sel !== 3'd7 || out !== 8'h80) begin
            errors++;
            $display("FAIL wrap_ch7: grant=%h sel=%0d out=%h want 80/7/80", grant, sel, out);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req      = 8'h08;
        in_valid = 1'b1;
        in_data  = 1'b1;
        tick();
        tick();
        checks++;
        if (grant !== 8'h08) begin
            errors++;
            $display("FAIL midrst_pre: grant=%h want 08", grant);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || out !== 8'h00) begin
            errors++;
            $display("FAIL midrst_zero: grant=%h sel=%0d busy=%b out=%h want zeros",
                     grant, sel, busy, out);
        end
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 8'h08 || sel !== 3'd3 || out !== 8'h08) begin
            errors++;
            $display("FAIL midrst_regrant: grant=%h sel=%0d out=%h want 08/3/08", grant, sel, out);
        end
    endtask

    task automatic test_min_dwell();
        logic [3:0] exp_g;
        logic [7:0] exp_o;
        logic       exp_b;
        do_reset();
        req1      = 4'b0110;
        in_valid1 = 1'b1;
        in_data1  = 2'b10;
        for (int i = 0; i < 9; i++) begin
            tick();
            if ((i % 3) == 0) begin
                exp_g = ((i / 3) % 2 == 1) ? 4'b0100 : 4'b0010;
                exp_o = ((i / 3) % 2 == 1) ? 8'b0010_0000 : 8'b0000_1000;
            end else begin
                exp_g = 4'b0000;
                exp_o = 8'h00;
            end
            exp_b = ((i % 3) != 2);
            checks++;
            if (grant1 !== exp_g || out1 !== exp_o || busy1 !== exp_b) begin
                errors++;
                $display("FAIL min_dwell cyc%0d: grant=%b out=%h busy=%b want %b/%h/%b",
                         i, grant1, out1, busy1, exp_g, exp_o, exp_b);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_single();
        test_all_requesting();
        test_early_drop();
        test_wrap_gating();
        test_reset_mid_grant();
        test_min_dwell();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
